// File: rtl/instr_encoder.sv
// RV32I request encoder (ADD/SUB/ADDI/LW/SW/BEQ) feeding an address-tagged FIFO toward the imem loader.
// Latency: accepted word visible the cycle after acceptance; backpressure via req_ready_o = !full && !clear_i && !rst_i.

module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_dat_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push;
  logic             pop;

  assign full_o     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push       = push_vld_i && !full_o;
  assign pop        = pop_rdy_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [31:0]       req_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              err_o,
  output logic [7:0]        err_cnt_o
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5
  } op_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
  } entry_t;

  op_e               op;
  logic [31:0]       imm;
  logic [31:0]       enc_dat;
  logic              enc_legal;
  logic              fits12;
  logic              fits13;
  logic              req_acc;
  logic              push_vld;
  logic              reject;
  logic              pop_rdy;
  logic              fifo_full;
  logic              fifo_empty;
  entry_t            push_dat;
  entry_t            head_dat;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  assign op  = op_e'(req_op_i);
  assign imm = req_imm_i;

  // Signed range checks: all bits above the sign bit must replicate it.
  assign fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits13 = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];

  always_comb begin
    enc_dat   = '0;
    enc_legal = 1'b0;
    case (op)
      OP_ADD: begin
        enc_dat   = {7'b0000000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'b0110011};
        enc_legal = 1'b1;
      end
      OP_SUB: begin
        enc_dat   = {7'b0100000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'b0110011};
        enc_legal = 1'b1;
      end
      OP_ADDI: begin
        enc_dat   = {imm[11:0], req_rs1_i, 3'b000, req_rd_i, 7'b0010011};
        enc_legal = fits12;
      end
      OP_LW: begin
        enc_dat   = {imm[11:0], req_rs1_i, 3'b010, req_rd_i, 7'b0000011};
        enc_legal = fits12;
      end
      OP_SW: begin
        enc_dat   = {imm[11:5], req_rs2_i, req_rs1_i, 3'b010, imm[4:0], 7'b0100011};
        enc_legal = fits12;
      end
      OP_BEQ: begin
        enc_dat   = {imm[12], imm[10:5], req_rs2_i, req_rs1_i, 3'b000,
                     imm[4:1], imm[11], 7'b1100011};
        enc_legal = fits13;
      end
      default: begin
        enc_dat   = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign req_ready_o = !fifo_full && !clear_i && !rst_i;
  assign req_acc     = req_valid_i && req_ready_o;
  assign push_vld    = req_acc && enc_legal;
  assign reject      = req_acc && !enc_legal;
  assign pop_rdy     = out_valid_o && out_ready_i && !clear_i;

  assign push_dat.addr  = addr_q;
  assign push_dat.instr = enc_dat;

  instr_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clear_i),
    .push_vld_i (push_vld),
    .push_dat_i (push_dat),
    .pop_rdy_i  (pop_rdy),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (head_dat)
  );

  always_comb begin
    addr_d    = addr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (clear_i) begin
      addr_d    = BASE_ADDR;
      err_cnt_d = '0;
    end else begin
      if (push_vld) begin
        addr_d = addr_q + ADDR_W'(4);
      end
      if (reject) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // An empty queue shows the address the next accepted word will receive.
  assign out_valid_o = !fifo_empty;
  assign out_instr_o = fifo_empty ? 32'h0 : head_dat.instr;
  assign out_addr_o  = fifo_empty ? addr_q : head_dat.addr;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
// Inputs change after the falling edge; outputs are sampled at the falling edge.

module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        req_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_addr;
  int          m_errcnt;
  bit          m_err;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_rd_i    (rd),
    .req_rs1_i   (rs1),
    .req_rs2_i   (rs2),
    .req_imm_i   (imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .out_addr_o  (out_addr),
    .err_o       (err),
    .err_cnt_o   (err_cnt)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] ref_encode(input int op, input int rd_v, input int rs1_v,
                                             input int rs2_v, input int imm_v, output bit ok);
    logic [31:0] u, r_d, r_s1, r_s2, w;
    u = imm_v; r_d = rd_v; r_s1 = rs1_v; r_s2 = rs2_v;
    ok = 1'b1;
    w = 32'h0;
    case (op)
      0: w = (r_s2 << 20) | (r_s1 << 15) | (r_d << 7) | 32'h33;
      1: w = 32'h40000000 | (r_s2 << 20) | (r_s1 << 15) | (r_d << 7) | 32'h33;
      2: begin
        ok = (imm_v >= -2048) && (imm_v <= 2047);
        w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (r_d << 7) | 32'h13;
      end
      3: begin
        ok = (imm_v >= -2048) && (imm_v <= 2047);
        w = ((u & 32'hFFF) << 20) | (r_s1 << 15) | (32'd2 << 12) | (r_d << 7) | 32'h03;
      end
      4: begin
        ok = (imm_v >= -2048) && (imm_v <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (r_s2 << 20) | (r_s1 << 15) | (32'd2 << 12)
          | ((u & 32'h1F) << 7) | 32'h23;
      end
      5: begin
        ok = (imm_v >= -4096) && (imm_v <= 4094) && ((imm_v % 2) == 0);
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r_s2 << 20)
          | (r_s1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
      end
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr   = BASE;
    m_errcnt = 0;
    m_err    = 1'b0;
  endtask

  task automatic set_req(input int op, input int a, input int b, input int c, input int v);
    req_valid = 1'b1;
    req_op    = op[2:0];
    rd        = a[4:0];
    rs1       = b[4:0];
    rs2       = c[4:0];
    imm       = v;
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    bit          ok, acc;
    logic [31:0] enc;
    enc = ref_encode(int'(req_op), int'(rd), int'(rs1), int'(rs2), int'($signed(imm)), ok);
    acc = req_valid && (exp_q.size() < DEPTH) && !clear;
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      m_err = acc && !ok;
      if (acc && !ok && m_errcnt < 255) m_errcnt++;
      if (acc && ok) begin
        exp_q.push_back({m_addr, enc});
        m_addr = m_addr + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    req_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_checks++; if (out_addr !== BASE) begin n_errors++; $display("FAIL reset_addr: got %h want %h", out_addr, BASE); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    set_req(2, 1, 0, 0, 5);
    tick();
    req_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_checks++; if (out_instr !== 32'h00500093) begin n_errors++; $display("FAIL addi_instr: got %h want 00500093", out_instr); end
    n_checks++; if (out_addr !== 32'h0) begin n_errors++; $display("FAIL addi_addr: got %h want 0", out_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    n_checks++; if (out_addr !== 32'h4) begin n_errors++; $display("FAIL addi_empty_addr: got %h want 4", out_addr); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b1;
    set_req(1, 3, 1, 2, 0);
    tick();
    n_checks++; if (out_instr !== 32'h402081B3 || out_addr !== 32'h0) begin n_errors++; $display("FAIL b2b_sub: got %h@%h want 402081b3@0", out_instr, out_addr); end
    set_req(4, 0, 3, 2, -4);
    tick();
    n_checks++; if (out_instr !== 32'hFE21AE23 || out_addr !== 32'h4) begin n_errors++; $display("FAIL b2b_sw: got %h@%h want fe21ae23@4", out_instr, out_addr); end
    set_req(5, 0, 1, 2, -8);
    tick();
    n_checks++; if (out_instr !== 32'hFE208CE3 || out_addr !== 32'h8) begin n_errors++; $display("FAIL b2b_beq: got %h@%h want fe208ce3@8", out_instr, out_addr); end
    req_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reject();
    do_clear();
    out_ready = 1'b1;
    set_req(2, 1, 1, 0, 2048);
    tick();
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rej_addi: err=%b valid=%b want 1,0", err, out_valid); end
    set_req(5, 0, 1, 2, 3);
    tick();
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rej_beq: err=%b valid=%b want 1,0", err, out_valid); end
    set_req(7, 1, 1, 1, 0);
    tick();
    n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rej_op7: err=%b valid=%b want 1,0", err, out_valid); end
    n_checks++; if (err_cnt !== 8'd3) begin n_errors++; $display("FAIL rej_count: got %0d want 3", err_cnt); end
    req_valid = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rej_pulse_end: got %b want 0", err); end
    set_req(0, 5, 6, 7, 0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_instr !== 32'h007302B3) begin n_errors++; $display("FAIL rej_next: got v=%b %h@%h want 007302b3@0", out_valid, out_instr, out_addr); end
    tick();
  endtask

  task automatic test_full();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(2, i + 1, 0, 0, i);
      tick();
    end
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    set_req(2, 9, 0, 0, 100);
    tick();
    n_checks++; if (req_ready !== 1'b0 || out_addr !== 32'h0) begin n_errors++; $display("FAIL full_hold: ready=%b addr=%h want 0,0", req_ready, out_addr); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_addr !== 32'h4 || req_ready !== 1'b1) begin n_errors++; $display("FAIL full_pop1: addr=%h ready=%b want 4,1", out_addr, req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (out_addr !== 32'h8) begin n_errors++; $display("FAIL full_pop2: got %h want 8", out_addr); end
    tick();
    n_checks++; if (out_addr !== 32'hC) begin n_errors++; $display("FAIL full_pop3: got %h want c", out_addr); end
    tick();
    n_checks++; if (out_addr !== 32'h10 || out_instr !== 32'h06400493) begin n_errors++; $display("FAIL full_fifth: got %h@%h want 06400493@10", out_instr, out_addr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL full_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_clear();
    do_clear();
    out_ready = 1'b0;
    set_req(6, 0, 0, 0, 0);
    tick();
    set_req(0, 1, 2, 3, 0);
    tick();
    tick();
    set_req(7, 1, 1, 1, 0);
    clear = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL clr_ready: got %b want 0", req_ready); end
    tick();
    clear = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_addr !== BASE) begin n_errors++; $display("FAIL clr_empty: valid=%b addr=%h want 0,%h", out_valid, out_addr, BASE); end
    n_checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_errors++; $display("FAIL clr_err: err=%b cnt=%0d want 0,0", err, err_cnt); end
    set_req(0, 1, 2, 3, 0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== BASE) begin n_errors++; $display("FAIL clr_next: valid=%b addr=%h want 1,%h", out_valid, out_addr, BASE); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_req(6, 0, 0, 0, 0);
    tick();
    set_req(3, 4, 5, 0, -100);
    tick();
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || req_ready !== 1'b0) begin n_errors++; $display("FAIL arst_now: valid=%b ready=%b want 0,0", out_valid, req_ready); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 2, 3, 4, 0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_addr !== BASE || err_cnt !== 8'd0) begin n_errors++; $display("FAIL arst_after: valid=%b addr=%h cnt=%0d want 1,%h,0", out_valid, out_addr, err_cnt, BASE); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_saturate();
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_req(6, 0, 0, 0, 0);
      tick();
      if (i == 253) begin
        n_checks++; if (err_cnt !== 8'd254) begin n_errors++; $display("FAIL sat_254: got %0d want 254", err_cnt); end
      end
    end
    n_checks++; if (err_cnt !== 8'd255 || err !== 1'b1) begin n_errors++; $display("FAIL sat_255: cnt=%0d err=%b want 255,1", err_cnt, err); end
    do_clear();
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL sat_clear: got %0d want 0", err_cnt); end
  endtask

  task automatic test_random();
    int edges[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, -4097};
    int v;
    logic [31:0] e_instr, e_addr;
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 2))
        0: v = edges[$urandom_range(0, 9)];
        1: v = int'($urandom_range(0, 9000)) - 4500;
        default: v = int'($urandom);
      endcase
      set_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), v);
      req_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      #1;
      n_checks++; if (req_ready !== ((exp_q.size() < DEPTH) && !clear)) begin n_errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, (exp_q.size() < DEPTH) && !clear); end
      tick();
      e_instr = (exp_q.size() > 0) ? exp_q[0][31:0] : 32'h0;
      e_addr  = (exp_q.size() > 0) ? exp_q[0][63:32] : m_addr;
      n_checks++; if (out_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, exp_q.size() > 0); end
      n_checks++; if (out_instr !== e_instr) begin n_errors++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, out_instr, e_instr); end
      n_checks++; if (out_addr !== e_addr) begin n_errors++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, out_addr, e_addr); end
      n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, m_err); end
      n_checks++; if (int'(err_cnt) !== m_errcnt) begin n_errors++; $display("FAIL rnd_errcnt c=%0d: got %0d want %0d", c, err_cnt, m_errcnt); end
    end
    clear = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addi();
    test_back_to_back();
    test_reject();
    test_full();
    test_clear();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
